// File: rtl/sw_result_collector_pkg.sv
// rtl/sw_result_collector_pkg.sv - shared widths, FSM states and score helper for the result collector
package sw_result_collector_pkg;

  localparam int CALC_BIT      = 16;  // signed score width
  localparam int MAX_T_NUM_BIT = 8;   // target index width
  localparam int SW_QID_BIT    = 8;   // default query-ID counter width

  typedef enum logic {
    ST_IDLE   = 1'b0,  // no beat since the last close
    ST_ACTIVE = 1'b1   // at least one beat folded into the current query
  } sw_state_e;

  // Strictly-greater signed compare; ties keep the earlier target.
  function automatic logic sw_beats(input logic signed [CALC_BIT-1:0] a,
                                    input logic signed [CALC_BIT-1:0] b);
    return a > b;
  endfunction

endpackage

// File: rtl/sw_result_fifo.sv
// rtl/sw_result_fifo.sv - synchronous record FIFO with registered head outputs
// Purpose: stores result records; head entry and valid flag are registers.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr_i        synchronous clear of contents and overflow flag
//   push_i/din_i write request and data (dropped when full without a pop)
//   pop_i        host ready; a pop occurs when pop_i and valid_o are high
//   valid_o/dout_o registered head entry, zero when empty
//   full_o/empty_o occupancy flags
//   overflow_o   sticky: a push was dropped
module sw_result_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_valid;
  logic [WIDTH-1:0] r_dout;
  logic             r_overflow;

  logic             w_pop;
  logic             w_full;
  logic             w_wr;
  logic             w_drop;
  logic [AW-1:0]    w_rd_ptr_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  assign w_pop  = pop_i & r_valid;
  assign w_full = (r_count == CW'(DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_wr   = push_i & (~w_full | w_pop);
  assign w_drop = push_i & w_full & ~w_pop;

  always_comb begin
    w_rd_ptr_nxt = r_rd_ptr + AW'(w_pop);
    w_count_nxt  = r_count + CW'(w_wr) - CW'(w_pop);
    w_head_nxt   = '0;
    if (w_count_nxt != '0) begin
      // The next head may be the entry being written this very cycle.
      if (w_wr && (r_wr_ptr == w_rd_ptr_nxt)) w_head_nxt = din_i;
      else                                    w_head_nxt = r_mem[w_rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr && !clr_i) r_mem[r_wr_ptr] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_dout     <= '0;
      r_overflow <= 1'b0;
    end else if (clr_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_dout     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_wr_ptr   <= r_wr_ptr + AW'(w_wr);
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_count    <= w_count_nxt;
      r_valid    <= (w_count_nxt != '0);
      r_dout     <= w_head_nxt;
      r_overflow <= r_overflow | w_drop;
    end
  end

  assign valid_o    = r_valid;
  assign dout_o     = r_dout;
  assign full_o     = w_full;
  assign empty_o    = ~r_valid;
  assign overflow_o = r_overflow;

endmodule

// File: rtl/sw_result_collector.sv
// rtl/sw_result_collector.sv - per-query best-score collector feeding a record FIFO
// Purpose: folds per-target score beats into a running best, and on each query
//   close pushes {qid, best score, best index, mismatch vs engine max}.
// Optional feature: define SW_RESULT_THRESH_EN to add thresh_i; queries whose
//   best score is below thresh_i push no record (qid still advances).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start_i           synchronous clear of all collection state (highest priority)
//   valid_i, result_i, match_idx_i  score beat
//   max_result_i      engine running maximum, sampled at close
//   change_q_i        closes the current query
//   thresh_i          (SW_RESULT_THRESH_EN only) minimum score worth recording
//   rec_valid_o/rec_ready_i  record handshake
//   rec_qid_o, rec_score_o, rec_idx_o, rec_mismatch_o  record fields
//   overflow_o        sticky: a record was dropped
module sw_result_collector
  import sw_result_collector_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int QID_BIT    = SW_QID_BIT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic                     valid_i,
  input  logic [CALC_BIT-1:0]      result_i,
  input  logic [MAX_T_NUM_BIT-1:0] match_idx_i,
  input  logic [CALC_BIT-1:0]      max_result_i,
  input  logic                     change_q_i,
`ifdef SW_RESULT_THRESH_EN
  input  logic [CALC_BIT-1:0]      thresh_i,
`endif
  output logic                     rec_valid_o,
  input  logic                     rec_ready_i,
  output logic [QID_BIT-1:0]       rec_qid_o,
  output logic [CALC_BIT-1:0]      rec_score_o,
  output logic [MAX_T_NUM_BIT-1:0] rec_idx_o,
  output logic                     rec_mismatch_o,
  output logic                     overflow_o
);

  localparam int REC_W = 1 + QID_BIT + CALC_BIT + MAX_T_NUM_BIT;

  sw_state_e                  r_state;
  sw_state_e                  w_state_nxt;
  logic signed [CALC_BIT-1:0] r_best_score;
  logic [MAX_T_NUM_BIT-1:0]   r_best_idx;
  logic [QID_BIT-1:0]         r_qid;

  logic signed [CALC_BIT-1:0] w_fold_score;
  logic [MAX_T_NUM_BIT-1:0]   w_fold_idx;
  logic                       w_nonempty;
  logic                       w_pass;
  logic                       w_push;
  logic                       w_mismatch;
  logic [REC_W-1:0]           w_rec_in;
  logic [REC_W-1:0]           w_rec_out;
  logic                       w_full;
  logic                       w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (start_i)         w_state_nxt = ST_IDLE;
    else if (change_q_i) w_state_nxt = ST_IDLE;
    else if (valid_i)    w_state_nxt = ST_ACTIVE;
  end

  // Running best including the current beat, so a beat arriving with the
  // close is part of the record.
  always_comb begin
    w_fold_score = r_best_score;
    w_fold_idx   = r_best_idx;
    if (valid_i && ((r_state == ST_IDLE) || sw_beats(result_i, r_best_score))) begin
      w_fold_score = result_i;
      w_fold_idx   = match_idx_i;
    end
  end

  assign w_nonempty = (r_state == ST_ACTIVE) | valid_i;
  assign w_mismatch = (w_fold_score != max_result_i);

`ifdef SW_RESULT_THRESH_EN
  assign w_pass = ~(w_fold_score < $signed(thresh_i));
`else
  assign w_pass = 1'b1;
`endif

  assign w_push   = ~start_i & change_q_i & w_nonempty & w_pass;
  assign w_rec_in = {w_mismatch, r_qid, w_fold_score, w_fold_idx};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_best_score <= '0;
      r_best_idx   <= '0;
      r_qid        <= '0;
    end else if (start_i) begin
      r_best_score <= '0;
      r_best_idx   <= '0;
      r_qid        <= '0;
    end else if (change_q_i) begin
      r_best_score <= '0;
      r_best_idx   <= '0;
      r_qid        <= r_qid + 1'b1;
    end else if (valid_i) begin
      r_best_score <= w_fold_score;
      r_best_idx   <= w_fold_idx;
    end
  end

  sw_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (start_i),
    .push_i     (w_push),
    .din_i      (w_rec_in),
    .pop_i      (rec_ready_i),
    .valid_o    (rec_valid_o),
    .dout_o     (w_rec_out),
    .full_o     (w_full),
    .empty_o    (w_empty),
    .overflow_o (overflow_o)
  );

  assign {rec_mismatch_o, rec_qid_o, rec_score_o, rec_idx_o} = w_rec_out;

  logic w_unused;
  assign w_unused = w_full ^ w_empty;

endmodule

// File: tb/tb_sw_result_collector.sv
// tb/tb_sw_result_collector.sv - directed self-checking bench for sw_result_collector
module tb_sw_result_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic        valid_i;
  logic [15:0] result_i;
  logic [7:0]  match_idx_i;
  logic [15:0] max_result_i;
  logic        change_q_i;
`ifdef SW_RESULT_THRESH_EN
  logic [15:0] thresh_i;
`endif
  logic        rec_valid_o;
  logic        rec_ready_i;
  logic [7:0]  rec_qid_o;
  logic [15:0] rec_score_o;
  logic [7:0]  rec_idx_o;
  logic        rec_mismatch_o;
  logic        overflow_o;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  sw_result_collector #(.FIFO_DEPTH(8), .QID_BIT(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .valid_i        (valid_i),
    .result_i       (result_i),
    .match_idx_i    (match_idx_i),
    .max_result_i   (max_result_i),
    .change_q_i     (change_q_i),
`ifdef SW_RESULT_THRESH_EN
    .thresh_i       (thresh_i),
`endif
    .rec_valid_o    (rec_valid_o),
    .rec_ready_i    (rec_ready_i),
    .rec_qid_o      (rec_qid_o),
    .rec_score_o    (rec_score_o),
    .rec_idx_o      (rec_idx_o),
    .rec_mismatch_o (rec_mismatch_o),
    .overflow_o     (overflow_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] score, input logic [7:0] idx);
    valid_i = 1'b1; result_i = score; match_idx_i = idx;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic close_q(input logic [15:0] maxr);
    change_q_i = 1'b1; max_result_i = maxr;
    tick();
    change_q_i = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] qid, input logic [15:0] score,
                           input logic [7:0] idx, input logic mm);
    check({tag, ".valid"}, 32'(rec_valid_o), 32'd1);
    check({tag, ".qid"}, 32'(rec_qid_o), 32'(qid));
    check({tag, ".score"}, 32'(rec_score_o), 32'(score));
    check({tag, ".idx"}, 32'(rec_idx_o), 32'(idx));
    check({tag, ".mm"}, 32'(rec_mismatch_o), 32'(mm));
    rec_ready_i = 1'b1;
    tick();
    rec_ready_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; valid_i = 1'b0; result_i = '0; match_idx_i = '0;
    max_result_i = '0; change_q_i = 1'b0; rec_ready_i = 1'b0;
`ifdef SW_RESULT_THRESH_EN
    thresh_i = 16'h8000;
`endif
    tick(); tick();
    check("rst.valid", 32'(rec_valid_o), 32'd0);
    check("rst.ovf", 32'(overflow_o), 32'd0);
    check("rst.qid", 32'(rec_qid_o), 32'd0);
    check("rst.score", 32'(rec_score_o), 32'd0);
    check("rst.idx", 32'(rec_idx_o), 32'd0);
    check("rst.mm", 32'(rec_mismatch_o), 32'd0);
    rst_n = 1'b1;
    tick();

    // Tie on 9 keeps idx 1.
    beat(16'd5, 8'd0); beat(16'd9, 8'd1); beat(16'd9, 8'd2);
    check("tie.pre_valid", 32'(rec_valid_o), 32'd0);
    close_q(16'd9);
    pop_check("tie", 8'd0, 16'd9, 8'd1, 1'b0);
    check("tie.post_valid", 32'(rec_valid_o), 32'd0);

    // Negative scores: -3 beats -7; max 0 -> mismatch.
    beat(16'hFFFD, 8'd3); beat(16'hFFF9, 8'd5);
    close_q(16'd0);
    pop_check("neg", 8'd1, 16'hFFFD, 8'd3, 1'b1);

    // Beat coincident with close.
    valid_i = 1'b1; result_i = 16'd12; match_idx_i = 8'd4;
    change_q_i = 1'b1; max_result_i = 16'd12;
    tick();
    valid_i = 1'b0; change_q_i = 1'b0;
    pop_check("coinc", 8'd2, 16'd12, 8'd4, 1'b0);

    // Empty queries advance qid without pushing; record holds while not ready.
    pulse_start();
    close_q(16'd0); close_q(16'd0);
    check("empty.valid", 32'(rec_valid_o), 32'd0);
    beat(16'd7, 8'd1); close_q(16'd7);
    tick(); tick();
    pop_check("empty", 8'd2, 16'd7, 8'd1, 1'b0);
    check("empty.drained", 32'(rec_valid_o), 32'd0);

    // Overflow: eight fit, ninth is dropped.
    pulse_start();
    for (int k = 0; k < 9; k++) begin
      if (k == 8) check("ovf.before", 32'(overflow_o), 32'd0);
      beat(16'(k + 1), 8'(k));
      close_q(16'(k + 1));
    end
    check("ovf.sticky", 32'(overflow_o), 32'd1);
    for (int k = 0; k < 8; k++) pop_check($sformatf("drain%0d", k), 8'(k), 16'(k + 1), 8'(k), 1'b0);
    check("ovf.empty", 32'(rec_valid_o), 32'd0);
    pulse_start();
    check("ovf.cleared", 32'(overflow_o), 32'd0);

    // Reset mid-query discards the partial query and qid.
    close_q(16'd0);
    beat(16'd20, 8'd6);
    rst_n = 1'b0;
    tick();
    check("mid.valid", 32'(rec_valid_o), 32'd0);
    rst_n = 1'b1;
    tick();
    beat(16'd3, 8'd1); beat(16'd4, 8'd2);
    close_q(16'd4);
    pop_check("mid", 8'd0, 16'd4, 8'd2, 1'b0);

    // start_i wins over a coincident beat and close.
    close_q(16'd0);
    start_i = 1'b1; valid_i = 1'b1; result_i = 16'd50; match_idx_i = 8'd9;
    change_q_i = 1'b1;
    tick();
    start_i = 1'b0; valid_i = 1'b0; change_q_i = 1'b0;
    check("startprio.valid", 32'(rec_valid_o), 32'd0);
    beat(16'd1, 8'd0); close_q(16'd0);
    pop_check("startprio", 8'd0, 16'd1, 8'd0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sw_result_collector.md
SW_RESULT_COLLECTOR -- requirements
Module: sw_result_collector

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, record FIFO depth; SHALL be a power of two, at least 2.
REQ-002 Parameter QID_BIT, default 8, query-ID counter width.
REQ-003 Port clk  in  1  sole clock; all state SHALL be updated on its rising edge.
REQ-004 Port rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port start_i  in  1  synchronous clear of all collection state.
REQ-006 Port valid_i  in  1  one per-target score beat present.
REQ-007 Port result_i  in  CALC_BIT  signed per-target score.
REQ-008 Port match_idx_i  in  MAX_T_NUM_BIT  target index of the beat.
REQ-009 Port max_result_i  in  CALC_BIT  engine running maximum, sampled at query close.
REQ-010 Port change_q_i  in  1  closes the current query.
REQ-011 Port rec_valid_o  out  1  record available.
REQ-012 Port rec_ready_i  in  1  host accepts record.
REQ-013 Port rec_qid_o / rec_score_o / rec_idx_o  out  QID_BIT / CALC_BIT / MAX_T_NUM_BIT  record fields.
REQ-014 Port rec_mismatch_o  out  1  record's best score differed from max_result_i.
REQ-015 Port overflow_o  out  1  sticky: a record was dropped.

Function
REQ-016 FSM states IDLE (no beat since last close) and ACTIVE; IDLE->ACTIVE on valid_i; ACTIVE->IDLE on change_q_i.
REQ-017 First beat of a query SHALL load best_score=result_i, best_idx=match_idx_i.
REQ-018 Later beats SHALL replace best only when result_i is strictly greater (signed); ties keep the earlier index.
REQ-019 When valid_i and change_q_i coincide, the beat SHALL be folded in before the record is formed.
REQ-020 On close in ACTIVE, record {qid, best_score, best_idx, mismatch=(best_score != max_result_i)} SHALL be pushed; rec_valid_o SHALL rise the next cycle when the FIFO was empty.
REQ-021 change_q_i in IDLE with no beat SHALL push nothing.
REQ-022 qid SHALL increment on every change_q_i, including empty queries, and wrap modulo 2^QID_BIT.
REQ-023 Pop SHALL occur when rec_valid_o and rec_ready_i are both high; record fields SHALL hold while rec_valid_o is high and rec_ready_i is low.
REQ-024 Push into a full FIFO with simultaneous pop SHALL succeed; push into a full FIFO without pop SHALL drop the record and set overflow_o.
REQ-025 start_i SHALL clear FSM, best, qid, FIFO and overflow_o, and SHALL take priority over a coincident beat or close.

Reset
REQ-026 rst_n low SHALL force IDLE, qid=0, best_score=0, best_idx=0, FIFO empty, rec_valid_o=0, overflow_o=0, and all record outputs to 0.
REQ-027 Reset asserted mid-query SHALL discard the partial query; no record SHALL be emitted.

Configuration
REQ-028 Macro SW_RESULT_THRESH_EN: when defined, add port thresh_i (in, CALC_BIT); a query whose best_score is less than thresh_i SHALL push no record, although qid still increments.
REQ-029 When SW_RESULT_THRESH_EN is undefined, the thresh_i port SHALL be absent and every non-empty query SHALL be recorded.

Structure
REQ-030 CALC_BIT, MAX_T_NUM_BIT, and the new constant SW_QID_BIT (default 8) SHALL come from the shared parameter include.
REQ-031 The FIFO SHALL be a sub-module sw_result_fifo (synchronous, registered outputs, full/empty flags, simultaneous push and pop).

Verification
REQ-032 Beats (5,idx0),(9,idx1),(9,idx2), then change_q with max_result_i=9 -> one record qid=0, score=9, idx=1, mismatch=0.
REQ-033 Beats with scores -3 and -7, then close with max_result_i=0 -> record score=-3, mismatch=1.
REQ-034 Nine closed queries with rec_ready_i held low and FIFO_DEPTH=8 -> 8 records retained, overflow_o=1, drained qids 0..7.
REQ-035 Closing beat (12,idx4) together with change_q_i -> record score=12, idx=4, rec_valid_o high one cycle later.
REQ-036 change_q_i twice with no beats, then one query -> one record, qid=2.
REQ-037 rst_n pulsed low mid-query, then 2 beats and a close -> one record, qid=0, containing only the post-reset beats.
